alu_op_sequencer: RTL and testbench

// - Initiator side of the 16-bit ALU port (A, B, ALU_Sel -> ALU_Out, CarryOut).
// - Accepts 16-bit instruction words over valid/ready, reads operands from a 4x16 register file,

---
 rtl/alu_op_sequencer_if.sv | 32 +++
 rtl/alu_op_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command, response and ALU-port bundle for alu_op_sequencer.
// The slave modport is the sequencer view. The master modport is the environment view:
// the command source, the response sink and the combinational ALU.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 16
) ();
  // instruction handshake
  logic              cmd_valid;
  logic              cmd_ready;
  logic [15:0]       cmd_instr;
  // ALU port (registered operands out, combinational result back)
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_sel;
  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;
  // result handshake
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_rd;

  modport slave (
    input  cmd_valid, cmd_instr, alu_out, alu_carry, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_rd
  );

  modport master (
    output cmd_valid, cmd_instr, alu_out, alu_carry, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_rd
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator for an external combinational 16-bit ALU.
// It accepts one instruction at a time and reads operands from a 4-entry register file.
// It drives registered operands to the ALU, captures the result, writes the result back
// and returns it over a valid/ready response.
// Optional feature macro: ALU_SEQ_ZFLAG_EN adds the zero_flag output (result==0 on CAPTURE).
module alu_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_sequencer_if.slave   bus,
  output logic                carry_flag
`ifdef ALU_SEQ_ZFLAG_EN
  ,
  output logic                zero_flag
`endif
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_LDI = 4'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [DATA_W-1:0] rf_q [REG_N];
  logic [DATA_W-1:0] rf_d [REG_N];
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [3:0]        alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_rd_q, rsp_rd_d;
  logic              carry_q, carry_d;
`ifdef ALU_SEQ_ZFLAG_EN
  logic              zero_q, zero_d;
`endif

  // Field decode of the latched instruction word. imm overlaps the rb field and is used only by LDI.
  logic [3:0]        op;
  logic [1:0]        rd, ra, rb;
  logic [7:0]        imm;
  logic [DATA_W-1:0] result;

  assign op  = instr_q[15:12];
  assign rd  = instr_q[11:10];
  assign ra  = instr_q[9:8];
  assign rb  = instr_q[7:6];
  assign imm = instr_q[7:0];

  // LDI bypasses the ALU. Every other opcode takes the ALU output as-is.
  assign result = (op == OP_LDI) ? {{(DATA_W-8){1'b0}}, imm} : bus.alu_out;

  // Next-state and datapath update: one instruction walks IDLE->ISSUE->CAPTURE->RESP.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    rf_d       = rf_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    rsp_data_d = rsp_data_q;
    rsp_rd_d   = rsp_rd_q;
    carry_d    = carry_q;
`ifdef ALU_SEQ_ZFLAG_EN
    zero_d     = zero_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          instr_d = bus.cmd_instr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // LDI leaves the ALU port untouched. ISSUE is still spent so that latency stays fixed.
        if (op != OP_LDI) begin
          alu_a_d   = rf_q[ra];
          alu_b_d   = rf_q[rb];
          alu_sel_d = op;
        end
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // The write-back lands here, so an rd that aliases ra/rb is seen by the next instruction.
        rf_d[rd]   = result;
        rsp_data_d = result;
        rsp_rd_d   = rd;
        if (op == OP_ADD) carry_d = bus.alu_carry;
`ifdef ALU_SEQ_ZFLAG_EN
        zero_d     = (result == '0);
`endif
        state_d    = RESP;
      end
      RESP: begin
        // The response holds until it is taken. A new command waits for the following IDLE cycle.
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Async reset drops any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= 4'b0000;
      rsp_data_q <= '0;
      rsp_rd_q   <= '0;
      carry_q    <= 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
      zero_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      rf_q       <= rf_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      rsp_data_q <= rsp_data_d;
      rsp_rd_q   <= rsp_rd_d;
      carry_q    <= carry_d;
`ifdef ALU_SEQ_ZFLAG_EN
      zero_q     <= zero_d;
`endif
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_rd    = rsp_rd_q;
  assign carry_flag    = carry_q;
`ifdef ALU_SEQ_ZFLAG_EN
  assign zero_flag     = zero_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed plus random instruction stream for alu_op_sequencer.
// The bench owns the combinational ALU and an architectural model: register file, carry and
// zero flags, and the last operands and opcode driven to the ALU.
module tb_alu_op_sequencer;
  logic clk;
  logic rst_n;
  logic carry_flag;
`ifdef ALU_SEQ_ZFLAG_EN
  logic zero_flag;
`endif
  int checks = 0;
  int errors = 0;

  alu_op_sequencer_if #(.DATA_W(16)) bus ();

  alu_op_sequencer #(.DATA_W(16), .REG_N(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .carry_flag (carry_flag)
`ifdef ALU_SEQ_ZFLAG_EN
    ,
    .zero_flag  (zero_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behaviour of the external ALU, shared by the ALU stub and the reference model
  function automatic logic [15:0] alu_f(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b);
    case (sel)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      4'd6:    return ~b;
      4'd7:    return a << 1;
      4'd8:    return a >> 1;
      default: return a;
    endcase
  endfunction

  always_comb begin
    bus.alu_out   = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);
    bus.alu_carry = (32'(bus.alu_a) + 32'(bus.alu_b)) > 32'hFFFF;
  end

  // Architectural model state
  logic [15:0] rf_m [4];
  logic        carry_m, zero_m;
  logic [15:0] a_m, b_m;
  logic [3:0]  sel_m;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) rf_m[i] = 16'h0;
    carry_m = 1'b0; zero_m = 1'b0;
    a_m = 16'h0; b_m = 16'h0; sel_m = 4'h0;
  endfunction

  function automatic logic [15:0] model_exec(input logic [15:0] ins);
    logic [3:0]  op;
    logic [15:0] res;
    op = ins[15:12];
    if (op == 4'd15) begin
      res = {8'h00, ins[7:0]};
    end else begin
      a_m = rf_m[ins[9:8]];
      b_m = rf_m[ins[7:6]];
      sel_m = op;
      res = alu_f(op, a_m, b_m);
      if (op == 4'd0) carry_m = (32'(a_m) + 32'(b_m)) > 32'hFFFF;
    end
    rf_m[ins[11:10]] = res;
    zero_m = (res == 16'h0);
    return res;
  endfunction

  function automatic logic [15:0] mk(input int op, input int rd, input int ra, input int rb);
    return {op[3:0], rd[1:0], ra[1:0], rb[1:0], 6'b0};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    return {4'hF, rd[1:0], 2'b00, imm[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] last_data;

  // Runs one instruction. Call it at a negedge in IDLE; it returns at a negedge in IDLE.
  // hold cycles of rsp_ready=0 happen in RESP. With keep_valid set, cmd_valid stays high
  // with held_ins through the stall and the release cycle.
  task automatic run(input logic [15:0] ins, input int hold, input bit keep_valid,
                     input logic [15:0] held_ins);
    logic [15:0] exp;
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_instr = ins;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    exp = model_exec(ins);
    @(negedge clk);
    chk("issue_no_rsp", bus.rsp_valid, 1'b0);
    chk("issue_not_ready", bus.cmd_ready, 1'b0);
    @(negedge clk);
    chk("capture_no_rsp", bus.rsp_valid, 1'b0);
    @(negedge clk);
    chk("rsp_valid_lat3", bus.rsp_valid, 1'b1);
    chk("rsp_data", bus.rsp_data, exp);
    chk("rsp_rd", bus.rsp_rd, ins[11:10]);
    chk("carry_flag", carry_flag, carry_m);
    chk("alu_a", bus.alu_a, a_m);
    chk("alu_b", bus.alu_b, b_m);
    chk("alu_sel", bus.alu_sel, sel_m);
`ifdef ALU_SEQ_ZFLAG_EN
    chk("zero_flag", zero_flag, zero_m);
`endif
    last_data = bus.rsp_data;
    for (int i = 0; i < hold; i++) begin
      if (keep_valid) begin bus.cmd_valid = 1'b1; bus.cmd_instr = held_ins; end
      @(negedge clk);
      chk("hold_valid", bus.rsp_valid, 1'b1);
      chk("hold_not_ready", bus.cmd_ready, 1'b0);
      chk("hold_data_stable", bus.rsp_data, exp);
      chk("hold_rd_stable", bus.rsp_rd, ins[11:10]);
    end
    if (keep_valid) begin bus.cmd_valid = 1'b1; bus.cmd_instr = held_ins; end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("release_idle", bus.rsp_valid, 1'b0);
    chk("release_ready", bus.cmd_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_instr = 16'h0;
    bus.rsp_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_alu_a", bus.alu_a, 16'h0);
    chk("rst_alu_b", bus.alu_b, 16'h0);
    chk("rst_alu_sel", bus.alu_sel, 4'h0);
    chk("rst_rsp_data", bus.rsp_data, 16'h0);
    chk("rst_rsp_rd", bus.rsp_rd, 2'd0);
    chk("rst_carry", carry_flag, 1'b0);
`ifdef ALU_SEQ_ZFLAG_EN
    chk("rst_zero", zero_flag, 1'b0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);

    // LDI basics and fixed latency
    run(ldi(1, 8'h34), 0, 0, 16'h0);
    chk("ldi_r1_data", last_data, 16'h0034);
    run(ldi(2, 8'h12), 1, 0, 16'h0);
    chk("ldi_r2_data", last_data, 16'h0012);

    // Build r1 = 0xFFFF: 0xFF, shifted left eight times, then ORed with 0xFF
    run(ldi(1, 8'hFF), 0, 0, 16'h0);
    run(ldi(3, 8'hFF), 0, 0, 16'h0);
    for (int i = 0; i < 8; i++) run(mk(7, 1, 1, 0), 0, 0, 16'h0);
    run(mk(3, 1, 1, 3), 0, 0, 16'h0);
    chk("r1_ffff", last_data, 16'hFFFF);
    run(ldi(2, 8'h01), 0, 0, 16'h0);
    run(mk(0, 3, 1, 2), 0, 0, 16'h0);
    chk("add_wrap_data", last_data, 16'h0000);
    chk("add_wrap_carry", carry_flag, 1'b1);
    run(mk(1, 0, 2, 1), 0, 0, 16'h0);
    chk("sub_data", last_data, 16'h0002);
    chk("sub_keeps_carry", carry_flag, 1'b1);
    run(mk(10, 0, 2, 0), 0, 0, 16'h0);
    chk("mov_data", last_data, 16'h0001);

    // Back-pressure: ten stalled cycles with a command pending, then exactly one accept
    run(mk(2, 3, 1, 2), 10, 1, ldi(0, 8'hAA));
    run(ldi(0, 8'hAA), 0, 0, 16'h0);
    chk("held_cmd_data", last_data, 16'h00AA);

`ifdef ALU_SEQ_ZFLAG_EN
    run(mk(4, 1, 1, 1), 0, 0, 16'h0);
    chk("xor_zero_data", last_data, 16'h0000);
    chk("xor_zero_flag", zero_flag, 1'b1);
    run(ldi(1, 8'h01), 0, 0, 16'h0);
    chk("ldi_clears_zero", zero_flag, 1'b0);
`endif

    // Reset asserted while an LDI r3 sits in CAPTURE
    run(mk(0, 3, 1, 1), 0, 0, 16'h0);
    bus.cmd_valid = 1'b1;
    bus.cmd_instr = ldi(3, 8'h55);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("midrst_alu_a", bus.alu_a, 16'h0);
    chk("midrst_alu_b", bus.alu_b, 16'h0);
    chk("midrst_alu_sel", bus.alu_sel, 4'h0);
    chk("midrst_rsp_data", bus.rsp_data, 16'h0);
    chk("midrst_rsp_rd", bus.rsp_rd, 2'd0);
    chk("midrst_carry", carry_flag, 1'b0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", bus.cmd_ready, 1'b1);
    chk("postrst_no_rsp", bus.rsp_valid, 1'b0);
    run(mk(9, 0, 3, 0), 0, 0, 16'h0);
    chk("postrst_r3_zero", last_data, 16'h0000);

    // Random instruction stream with random response stalls
    for (int i = 0; i < 40; i++) begin
      r = 16'($urandom);
      if (i < 8) r[15:12] = 4'hF;
      run(r, int'($urandom_range(0, 3)), 0, 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
